cond_resolve: RTL and testbench

Multi-cycle condition-resolution unit for the multicycle MIPS datapath. It consumes the ALU comparator's condition flags and turns them into control actions: branch PC load with computed target, link write, trap request, and conditional-move write enable. The control unit hands it one conditional instruction at a time through a start/done handshake. The unit drives the comparator's operation select, waits for the flags to settle, samples them, and pulses the resulting action for one cycle.

---
 rtl/cond_resolve.sv | 153 +++++++++++++++
 tb/tb_cond_resolve.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_resolve.sv
// cond_resolve: condition-resolution unit for the multicycle MIPS datapath.
// The unit takes one conditional instruction per start/done handshake and
// drives the comparator select. It waits for the comparator flags to settle,
// samples the tested flag bit, and then pulses the resulting control action
// (branch, link, trap or conditional move) for one cycle together with done.
module cond_resolve #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  cond_op,
  input  logic [31:0] pc_plus4,
  input  logic [15:0] offset,
  input  logic [3:0]  cmp_flags,
  output logic [3:0]  cmp_sel,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic        pc_load,
  output logic [31:0] pc_target,
  output logic        link_we,
  output logic        trap_req,
  output logic        mov_we
);

  // Settle values below 1 behave as 1.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(SETTLE_EFF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EVAL  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    ACT_BRANCH      = 2'd0,
    ACT_BRANCH_LINK = 2'd1,
    ACT_TRAP        = 2'd2,
    ACT_MOVE        = 2'd3
  } action_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [3:0]       op_q;
  logic             accept;

  // Decoded view of the latched operation.
  logic [3:0]       dec_sel;
  logic [1:0]       dec_bit;
  action_t          dec_act;
  logic             flag_hit;
  logic             is_branch;

  assign accept    = (state == IDLE) && start;
  assign flag_hit  = cmp_flags[dec_bit];
  assign is_branch = (dec_act == ACT_BRANCH) || (dec_act == ACT_BRANCH_LINK);

  // Decode the latched op into comparator select, tested flag bit and action.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    dec_sel = 4'd0;
    dec_bit = 2'd0;
    dec_act = ACT_BRANCH;
    case (op_q)
      4'd0:  begin dec_sel = 4'd8;  dec_bit = 2'd0; dec_act = ACT_BRANCH;      end // BEQ
      4'd1:  begin dec_sel = 4'd12; dec_bit = 2'd0; dec_act = ACT_BRANCH;      end // BNE
      4'd2:  begin dec_sel = 4'd7;  dec_bit = 2'd0; dec_act = ACT_BRANCH;      end // BGEZ
      4'd3:  begin dec_sel = 4'd7;  dec_bit = 2'd0; dec_act = ACT_BRANCH_LINK; end // BGEZAL
      4'd4:  begin dec_sel = 4'd9;  dec_bit = 2'd0; dec_act = ACT_BRANCH;      end // BLTZ
      4'd5:  begin dec_sel = 4'd9;  dec_bit = 2'd0; dec_act = ACT_BRANCH_LINK; end // BLTZAL
      4'd6:  begin dec_sel = 4'd10; dec_bit = 2'd0; dec_act = ACT_BRANCH;      end // BGTZ
      4'd7:  begin dec_sel = 4'd11; dec_bit = 2'd0; dec_act = ACT_BRANCH;      end // BLEZ
      4'd8:  begin dec_sel = 4'd8;  dec_bit = 2'd2; dec_act = ACT_TRAP;        end // TEQ
      4'd9:  begin dec_sel = 4'd12; dec_bit = 2'd0; dec_act = ACT_TRAP;        end // TNE
      4'd10: begin dec_sel = 4'd14; dec_bit = 2'd2; dec_act = ACT_TRAP;        end // TGE
      4'd11: begin dec_sel = 4'd14; dec_bit = 2'd3; dec_act = ACT_TRAP;        end // TGEU
      4'd12: begin dec_sel = 4'd15; dec_bit = 2'd2; dec_act = ACT_TRAP;        end // TLT
      4'd13: begin dec_sel = 4'd15; dec_bit = 2'd3; dec_act = ACT_TRAP;        end // TLTU
      4'd14: begin dec_sel = 4'd6;  dec_bit = 2'd0; dec_act = ACT_MOVE;        end // MOVZ
      default: begin dec_sel = 4'd13; dec_bit = 2'd0; dec_act = ACT_MOVE;      end // MOVN
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: ISSUE lasts until the settle counter runs out.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ISSUE;
      ISSUE:   if (settle_cnt == CNT_W'(1)) state_nxt = EVAL;
      EVAL:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs that follow the state directly.
  always_comb begin
    busy    = (state != IDLE);
    cmp_sel = 4'd0;
    if ((state == ISSUE) || (state == EVAL)) cmp_sel = dec_sel;
  end

  // Operand capture at acceptance and the settle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= 4'd0;
      pc_target  <= 32'd0;
      settle_cnt <= '0;
    end else if (accept) begin
      op_q       <= cond_op;
      pc_target  <= pc_plus4 + {{14{offset[15]}}, offset, 2'b00};
      settle_cnt <= CNT_W'(SETTLE_EFF);
    end else if (state == ISSUE) begin
      settle_cnt <= settle_cnt - CNT_W'(1);
    end
  end

  // Condition result: cleared on acceptance, sampled from the flags in EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              taken <= 1'b0;
    else if (accept)         taken <= 1'b0;
    else if (state == EVAL)  taken <= flag_hit;
  end

  // Action pulses are registered in EVAL so they are high only during RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      pc_load  <= 1'b0;
      link_we  <= 1'b0;
      trap_req <= 1'b0;
      mov_we   <= 1'b0;
    end else begin
      done     <= (state == EVAL);
      pc_load  <= (state == EVAL) && is_branch && flag_hit;
      link_we  <= (state == EVAL) && (dec_act == ACT_BRANCH_LINK);
      trap_req <= (state == EVAL) && (dec_act == ACT_TRAP) && flag_hit;
      mov_we   <= (state == EVAL) && (dec_act == ACT_MOVE) && flag_hit;
    end
  end

endmodule

// File: tb/tb_cond_resolve.sv
// tb_cond_resolve: drives two instances (settle 1 and settle 3) with shared
// inputs. A cycle-count reference model predicts every output after every
// clock edge, and directed cases pin the model with literal values.
module tb_cond_resolve;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  cond_op = 4'd0;
  logic [31:0] pc_plus4 = 32'd0;
  logic [15:0] offset = 16'd0;
  logic [3:0]  cmp_flags = 4'd0;

  logic [3:0]  sel1, sel3;
  logic        busy1, done1, taken1, pcl1, link1, trap1, mov1;
  logic        busy3, done3, taken3, pcl3, link3, trap3, mov3;
  logic [31:0] tgt1, tgt3;

  cond_resolve #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .cond_op(cond_op),
    .pc_plus4(pc_plus4), .offset(offset), .cmp_flags(cmp_flags),
    .cmp_sel(sel1), .busy(busy1), .done(done1), .taken(taken1),
    .pc_load(pcl1), .pc_target(tgt1), .link_we(link1),
    .trap_req(trap1), .mov_we(mov1)
  );

  cond_resolve #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .cond_op(cond_op),
    .pc_plus4(pc_plus4), .offset(offset), .cmp_flags(cmp_flags),
    .cmp_sel(sel3), .busy(busy3), .done(done3), .taken(taken3),
    .pc_load(pcl3), .pc_target(tgt3), .link_we(link3),
    .trap_req(trap3), .mov_we(mov3)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Operation table: comparator select and tested flag bit per cond_op.
  localparam int SEL_TBL [16] = '{8, 12, 7, 7, 9, 9, 10, 11, 8, 12, 14, 14, 15, 15, 6, 13};
  localparam int BIT_TBL [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2, 3, 2, 3, 0, 0};

  // Model: whether an instruction is in flight, edges since acceptance,
  // the accepted op, the computed target and the sampled result.
  typedef struct {
    bit          active;
    int          n;
    logic [3:0]  op;
    logic [31:0] target;
    bit          taken;
  } m_t;

  function automatic m_t step(input m_t m, input int s, input logic rn, input logic st,
                              input logic [3:0] op, input logic [31:0] pc,
                              input logic [15:0] off, input logic [3:0] fl);
    logic [31:0] se;
    m_t r;
    r = m;
    if (!rn) begin
      r.active = 1'b0; r.n = 0; r.op = 4'd0; r.target = 32'd0; r.taken = 1'b0;
    end else if (!r.active) begin
      if (st) begin
        se       = {{16{off[15]}}, off};
        r.active = 1'b1;
        r.n      = 0;
        r.op     = op;
        r.target = pc + (se << 2);
        r.taken  = 1'b0;
      end
    end else begin
      r.n = r.n + 1;
      if (r.n == s + 1) r.taken = fl[BIT_TBL[r.op]];
      if (r.n == s + 2) r.active = 1'b0;
    end
    return r;
  endfunction

  task automatic compare(input string tag, input m_t m, input int s,
                         input logic [3:0] sel, input logic busy, input logic done,
                         input logic taken, input logic pcl, input logic [31:0] tgt,
                         input logic link, input logic trap, input logic mov);
    bit pulse;
    bit exp_sel_on;
    pulse      = m.active && (m.n == s + 1);
    exp_sel_on = m.active && (m.n <= s);
    check({tag, ".busy"},    32'(busy),  32'(m.active));
    check({tag, ".cmp_sel"}, 32'(sel),   exp_sel_on ? 32'(SEL_TBL[m.op]) : 32'd0);
    check({tag, ".done"},    32'(done),  32'(pulse));
    check({tag, ".taken"},   32'(taken), 32'(m.taken));
    check({tag, ".target"},  tgt,        m.target);
    check({tag, ".pc_load"}, 32'(pcl),   32'(pulse && (m.op < 4'd8) && m.taken));
    check({tag, ".link_we"}, 32'(link),  32'(pulse && ((m.op == 4'd3) || (m.op == 4'd5))));
    check({tag, ".trap"},    32'(trap),  32'(pulse && (m.op >= 4'd8) && (m.op < 4'd14) && m.taken));
    check({tag, ".mov_we"},  32'(mov),   32'(pulse && (m.op >= 4'd14) && m.taken));
  endtask

  m_t m1;
  m_t m3;

  // Advance the model on each rising edge, then compare just after it.
  always @(posedge clk) begin
    m1 = step(m1, 1, rst_n, start, cond_op, pc_plus4, offset, cmp_flags);
    m3 = step(m3, 3, rst_n, start, cond_op, pc_plus4, offset, cmp_flags);
    #1;
    compare("s1", m1, 1, sel1, busy1, done1, taken1, pcl1, tgt1, link1, trap1, mov1);
    compare("s3", m3, 3, sel3, busy3, done3, taken3, pcl3, tgt3, link3, trap3, mov3);
  end

  // Snapshot of the settle-1 instance at its done cycle.
  int          lat1, lat3;
  logic [3:0]  snap_sel;
  logic        snap_pcl, snap_trap, snap_mov, snap_link, snap_taken;
  logic [31:0] snap_tgt;

  task automatic wait_idle();
    for (int i = 0; i < 30 && (busy1 || busy3); i++) @(negedge clk);
    check("idle_wait", 32'(busy1 || busy3), 32'd0);
  endtask

  // One instruction, flags held for the whole transaction. With glitch set,
  // a second start carrying a different op is raised during ISSUE.
  task automatic do_op(input logic [3:0] op, input logic [31:0] pc, input logic [15:0] off,
                       input logic [3:0] fl, input bit glitch);
    wait_idle();
    start = 1'b1; cond_op = op; pc_plus4 = pc; offset = off; cmp_flags = fl;
    lat1 = 0; lat3 = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 1) begin
        snap_sel = sel1;
        if (glitch) begin
          start = 1'b1; cond_op = 4'd9; pc_plus4 = ~pc; offset = 16'h1234;
        end
      end
      if (done1 && lat1 == 0) begin
        lat1 = c; snap_pcl = pcl1; snap_trap = trap1; snap_mov = mov1;
        snap_link = link1; snap_taken = taken1; snap_tgt = tgt1;
      end
      if (done3 && lat3 == 0) lat3 = c;
    end
    start = 1'b0;
  endtask

  int seen;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.busy",   32'(busy1), 32'd0);
    check("rst.sel",    32'(sel1),  32'd0);
    check("rst.taken",  32'(taken1), 32'd0);
    check("rst.target", tgt1,       32'd0);
    check("rst.done3",  32'(done3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // BEQ taken with a negative offset.
    do_op(4'd0, 32'h0000_0100, 16'hFFFE, 4'b0001, 1'b0);
    check("beq.lat1",   32'(lat1), 32'd3);
    check("beq.lat3",   32'(lat3), 32'd5);
    check("beq.target", snap_tgt,  32'h0000_00F8);
    check("beq.pcl",    32'(snap_pcl), 32'd1);
    check("beq.taken",  32'(snap_taken), 32'd1);
    check("beq.sel",    32'(snap_sel), 32'd8);

    // TGEU tests flag bit 3 only.
    do_op(4'd11, 32'h0000_2000, 16'h0010, 4'b1000, 1'b0);
    check("tgeu1.trap",  32'(snap_trap), 32'd1);
    check("tgeu1.pcl",   32'(snap_pcl),  32'd0);
    check("tgeu1.taken", 32'(snap_taken), 32'd1);
    do_op(4'd11, 32'h0000_2000, 16'h0010, 4'b0100, 1'b0);
    check("tgeu0.lat",   32'(lat1), 32'd3);
    check("tgeu0.trap",  32'(snap_trap), 32'd0);
    check("tgeu0.taken", 32'(snap_taken), 32'd0);

    // BLTZAL links even when not taken.
    do_op(4'd5, 32'h0040_0000, 16'h0008, 4'b0000, 1'b0);
    check("bltzal.link", 32'(snap_link), 32'd1);
    check("bltzal.pcl",  32'(snap_pcl),  32'd0);

    // MOVN taken raises only mov_we.
    do_op(4'd15, 32'h0000_0000, 16'h0000, 4'b0001, 1'b0);
    check("movn.mov",  32'(snap_mov),  32'd1);
    check("movn.pcl",  32'(snap_pcl),  32'd0);
    check("movn.trap", 32'(snap_trap), 32'd0);
    check("movn.link", 32'(snap_link), 32'd0);

    // Target wrap-around plus an ignored start during ISSUE.
    do_op(4'd0, 32'hFFFF_FFFC, 16'h0001, 4'b0001, 1'b1);
    check("wrap.target", snap_tgt, 32'h0000_0000);
    check("wrap.pcl",    32'(snap_pcl),  32'd1);
    check("wrap.trap",   32'(snap_trap), 32'd0);
    check("wrap.lat",    32'(lat1), 32'd3);

    // Randomized traffic with occasional single-cycle resets.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 3) == 0);
      cond_op   = 4'($urandom);
      pc_plus4  = $urandom;
      offset    = 16'($urandom);
      cmp_flags = 4'($urandom);
      rst_n     = ($urandom_range(0, 199) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b0;

    // Reset asserted while the settle-1 instance is in EVAL.
    wait_idle();
    start = 1'b1; cond_op = 4'd0; pc_plus4 = 32'h0000_0100; offset = 16'h0004; cmp_flags = 4'b0001;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("rsteval.sel_before", 32'(sel1), 32'd8);
    rst_n = 1'b0;
    #1;
    check("rsteval.busy",   32'(busy1),  32'd0);
    check("rsteval.sel",    32'(sel1),   32'd0);
    check("rsteval.target", tgt1,        32'd0);
    check("rsteval.taken",  32'(taken1), 32'd0);
    check("rsteval.busy3",  32'(busy3),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done1 || done3 || pcl1 || pcl3) seen++;
    end
    check("rsteval.no_done", 32'(seen), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
